serial_io_bridge: RTL and testbench
===================================

Name: serial_io_bridge

Overview:
Byte-wide buffered bridge between the external serial link and the processor's serial port (serial_in / serial_valid_in / serial_rden_out on the RX side, serial_out / serial_wren_out / serial_ready_in on the TX side). It contains two independent show-ahead FIFOs. The RX FIFO accepts bytes from the external source and presents them to the processor; the TX FIFO accepts bytes written by the processor and drains them to the external sink. It sits directly upstream and downstream of the processor core in the top-level, so the core never stalls on link timing.

Parameters:
DEPTH_LOG2, 4, log2 of each FIFO's depth (DEPTH = 2**DEPTH_LOG2; legal 1..8); both FIFOs use the same depth.

Ports:
clock  input  1  single system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising edge of clock; 0 = reset
ext_rx_data  input  8  byte from external serial source
ext_rx_valid  input  1  ext_rx_data valid this cycle
ext_rx_ready  output  1  bridge can accept an RX byte this cycle
cpu_rx_data  output  8  head of RX FIFO; drives processor serial_in
cpu_rx_valid  output  1  RX FIFO non-empty; drives processor serial_valid_in
cpu_rx_rden  input  1  pop RX head; driven by processor serial_rden_out
cpu_tx_data  input  8  byte from processor serial_out
cpu_tx_wren  input  1  push cpu_tx_data; driven by processor serial_wren_out
cpu_tx_ready  output  1  TX FIFO not full; drives processor serial_ready_in
ext_tx_data  output  8  head of TX FIFO to external sink
ext_tx_valid  output  1  TX FIFO non-empty
ext_tx_ready  input  1  external sink accepts ext_tx_data this cycle

Behaviour:
- Each FIFO: DEPTH x 8 register array, write and read pointers of DEPTH_LOG2+1 bits (MSB is the wrap bit). Empty = pointers equal. Full = low bits equal and MSBs differ. Pointers wrap modulo 2*DEPTH naturally.
- Reset (reset==0 at an edge): both pointer pairs return to 0 and the array contents are don't-care. While reset is low, ext_rx_ready=0, cpu_rx_valid=0, cpu_tx_ready=0, ext_tx_valid=0, cpu_rx_data=8'h00 and ext_tx_data=8'h00. Reset mid-transfer discards all buffered bytes; no partial state survives.
- RX push: occurs at an edge when ext_rx_valid && ext_rx_ready. ext_rx_ready = reset && !rx_full. It depends only on registered state, never combinationally on cpu_rx_rden.
- RX pop: occurs at an edge when cpu_rx_rden && cpu_rx_valid. cpu_rx_rden while empty is ignored, and the pointers do not move.
- TX push: occurs when cpu_tx_wren && cpu_tx_ready. cpu_tx_wren while full drops the byte silently; the pointers do not move.
- TX pop: occurs when ext_tx_valid && ext_tx_ready.
- Show-ahead: the head byte is visible combinationally from the array whenever valid=1. Data outputs read 8'h00 when the FIFO is empty.
- Latency: a byte pushed at edge N into an empty FIFO gives valid=1 and head=that byte in the cycle after edge N (one cycle, no bypass).
- Simultaneous push and pop in the same FIFO, same edge, FIFO non-empty and not full: both occur and occupancy is unchanged.
- Full FIFO: push is blocked by ready=0, so a simultaneous pop alone frees one slot, and ready returns 1 in the next cycle.
- Empty FIFO with simultaneous push: the pop is ignored and the push occurs.
- Ordering: strict FIFO; byte order is preserved across pointer wrap-around.
- RX and TX paths are fully independent; no arbitration between them.

Optional Feature:
Macro SERIAL_BRIDGE_STATUS_EN.
- Defined: adds these output ports:
  - rx_count [DEPTH_LOG2:0] and tx_count [DEPTH_LOG2:0]: occupancy, equal to wr_ptr - rd_ptr, range 0..DEPTH.
  - tx_drop (1 bit): sticky; set at an edge where cpu_tx_wren && !cpu_tx_ready with reset high; cleared only by reset.
  - rx_underflow (1 bit): sticky; set at an edge where cpu_rx_rden && !cpu_rx_valid with reset high; cleared only by reset.
  - All four outputs are 0 during and immediately after reset.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles with ext_rx_valid=1 and cpu_tx_wren=1 -> all ready/valid outputs 0, both data outputs 8'h00, no push occurs; release reset -> ext_rx_ready=1, cpu_tx_ready=1 in the first cycle after.
- RX latency and order: push 8'hA5 then 8'h3C on consecutive edges, with no rden -> cpu_rx_valid=1 with data 8'hA5 one cycle after the first push; after rden, data 8'h3C; after a second rden, valid=0 and data 8'h00.
- RX full and wrap (DEPTH_LOG2=4): push 16 bytes 8'h00..8'h0F -> ext_rx_ready=0 after the 16th; a 17th byte 8'hFF held valid is not accepted; pop 1 -> ready=1 next cycle and 8'hFF is accepted; drain -> sequence 8'h01..8'h0F, 8'hFF.
- Simultaneous RX push and pop at occupancy 3 -> occupancy remains 3 (rx_count=3 when STATUS_EN) and the head advances by one.
- TX backpressure: cpu writes 8'h11, 8'h22, 8'h33 with ext_tx_ready=0 -> ext_tx_valid=1 and data 8'h11 held; raise ext_tx_ready for 3 cycles -> 8'h11, 8'h22, 8'h33 emitted in order, then valid=0.
- STATUS_EN: fill TX (16 bytes), then cpu_tx_wren with 8'h99 -> byte dropped and tx_drop=1 sticky; rden on empty RX -> rx_underflow=1; both clear only on reset=0.

Source files
------------

// File: rtl/serial_io_bridge.sv
// serial_io_bridge: byte-wide bridge with two independent show-ahead FIFOs.
//   RX FIFO: external source -> processor serial port.
//   TX FIFO: processor serial port -> external sink.
// Optional status outputs (occupancy counts and sticky error flags) are
// compiled in when SERIAL_BRIDGE_STATUS_EN is defined.
//
// Handshake rule used on every port pair: a byte moves at a rising edge of
// clock exactly when its valid/enable and its ready/valid partner are both 1.
// Ready and valid outputs depend only on registered state and reset, never
// combinationally on the partner's request.

// Show-ahead FIFO with wrap-bit pointers; head byte is read combinationally.
module serial_io_bridge_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            i_wr_data,
  input  logic                  i_wr_en,
  output logic                  o_wr_ready,
  output logic [7:0]            o_rd_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_en
`ifdef SERIAL_BRIDGE_STATUS_EN
  ,
  output logic [DEPTH_LOG2:0]   o_count
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [7:0]          r_mem [DEPTH];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]) &&
                   (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]);

  // Reset gates ready/valid so nothing is offered or accepted while held.
  assign o_wr_ready = reset && !w_full;
  assign o_rd_valid = reset && !w_empty;
  assign o_rd_data  = o_rd_valid ? r_mem[r_rd_ptr[DEPTH_LOG2-1:0]] : 8'h00;

  // A pop on an empty FIFO or a push on a full one is simply not a transfer.
  assign w_push = i_wr_en && o_wr_ready;
  assign w_pop  = i_rd_en && o_rd_valid;

`ifdef SERIAL_BRIDGE_STATUS_EN
  assign o_count = r_wr_ptr - r_rd_ptr;
`endif

  // Pointer update; reset discards all buffered bytes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage array; contents after reset are don't-care.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= i_wr_data;
  end

endmodule

// Top level: two FIFOs wired to the external link and the processor port.
module serial_io_bridge #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          ext_rx_data,
  input  logic                ext_rx_valid,
  output logic                ext_rx_ready,
  output logic [7:0]          cpu_rx_data,
  output logic                cpu_rx_valid,
  input  logic                cpu_rx_rden,
  input  logic [7:0]          cpu_tx_data,
  input  logic                cpu_tx_wren,
  output logic                cpu_tx_ready,
  output logic [7:0]          ext_tx_data,
  output logic                ext_tx_valid,
  input  logic                ext_tx_ready
`ifdef SERIAL_BRIDGE_STATUS_EN
  ,
  output logic [DEPTH_LOG2:0] rx_count,
  output logic [DEPTH_LOG2:0] tx_count,
  output logic                tx_drop,
  output logic                rx_underflow
`endif
);

  serial_io_bridge_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clock      (clock),
    .reset      (reset),
    .i_wr_data  (ext_rx_data),
    .i_wr_en    (ext_rx_valid),
    .o_wr_ready (ext_rx_ready),
    .o_rd_data  (cpu_rx_data),
    .o_rd_valid (cpu_rx_valid),
    .i_rd_en    (cpu_rx_rden)
`ifdef SERIAL_BRIDGE_STATUS_EN
    ,
    .o_count    (rx_count)
`endif
  );

  serial_io_bridge_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clock      (clock),
    .reset      (reset),
    .i_wr_data  (cpu_tx_data),
    .i_wr_en    (cpu_tx_wren),
    .o_wr_ready (cpu_tx_ready),
    .o_rd_data  (ext_tx_data),
    .o_rd_valid (ext_tx_valid),
    .i_rd_en    (ext_tx_ready)
`ifdef SERIAL_BRIDGE_STATUS_EN
    ,
    .o_count    (tx_count)
`endif
  );

`ifdef SERIAL_BRIDGE_STATUS_EN
  logic r_tx_drop;
  logic r_rx_underflow;

  assign tx_drop      = r_tx_drop;
  assign rx_underflow = r_rx_underflow;

  // Sticky error flags: a dropped TX write or an RX read with nothing buffered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_tx_drop      <= 1'b0;
      r_rx_underflow <= 1'b0;
    end else begin
      if (cpu_tx_wren && !cpu_tx_ready) r_tx_drop      <= 1'b1;
      if (cpu_rx_rden && !cpu_rx_valid) r_rx_underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_serial_io_bridge.sv
// Testbench for serial_io_bridge: directed test-plan sequences followed by
// randomized traffic, all checked every cycle against a queue-based model.
module tb_serial_io_bridge;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 2 ** DEPTH_LOG2;

  logic                clock;
  logic                reset;
  logic [7:0]          ext_rx_data;
  logic                ext_rx_valid;
  logic                ext_rx_ready;
  logic [7:0]          cpu_rx_data;
  logic                cpu_rx_valid;
  logic                cpu_rx_rden;
  logic [7:0]          cpu_tx_data;
  logic                cpu_tx_wren;
  logic                cpu_tx_ready;
  logic [7:0]          ext_tx_data;
  logic                ext_tx_valid;
  logic                ext_tx_ready;
`ifdef SERIAL_BRIDGE_STATUS_EN
  logic [DEPTH_LOG2:0] rx_count;
  logic [DEPTH_LOG2:0] tx_count;
  logic                tx_drop;
  logic                rx_underflow;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit sb_en    = 1'b0;

  // Reference model: byte queues plus sticky flags.
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  bit         m_tx_drop;
  bit         m_rx_uf;

  serial_io_bridge #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clock        (clock),
    .reset        (reset),
    .ext_rx_data  (ext_rx_data),
    .ext_rx_valid (ext_rx_valid),
    .ext_rx_ready (ext_rx_ready),
    .cpu_rx_data  (cpu_rx_data),
    .cpu_rx_valid (cpu_rx_valid),
    .cpu_rx_rden  (cpu_rx_rden),
    .cpu_tx_data  (cpu_tx_data),
    .cpu_tx_wren  (cpu_tx_wren),
    .cpu_tx_ready (cpu_tx_ready),
    .ext_tx_data  (ext_tx_data),
    .ext_tx_valid (ext_tx_valid),
    .ext_tx_ready (ext_tx_ready)
`ifdef SERIAL_BRIDGE_STATUS_EN
    ,
    .rx_count     (rx_count),
    .tx_count     (tx_count),
    .tx_drop      (tx_drop),
    .rx_underflow (rx_underflow)
`endif
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge; inputs change 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard/monitor: compares DUT outputs with the model at each falling
  // edge, then applies the transfers the next rising edge will perform.
  always @(negedge clock) begin
    if (sb_en) begin
      if (!reset) begin
        chk("rst_ext_rx_ready", ext_rx_ready, 0);
        chk("rst_cpu_rx_valid", cpu_rx_valid, 0);
        chk("rst_cpu_rx_data",  cpu_rx_data,  0);
        chk("rst_cpu_tx_ready", cpu_tx_ready, 0);
        chk("rst_ext_tx_valid", ext_tx_valid, 0);
        chk("rst_ext_tx_data",  ext_tx_data,  0);
        rx_q.delete();
        tx_q.delete();
        m_tx_drop = 1'b0;
        m_rx_uf   = 1'b0;
      end else begin
        bit rx_push, rx_pop, tx_push, tx_pop;
        chk("ext_rx_ready", ext_rx_ready, int'(rx_q.size() < DEPTH));
        chk("cpu_rx_valid", cpu_rx_valid, int'(rx_q.size() > 0));
        chk("cpu_rx_data",  cpu_rx_data,  (rx_q.size() > 0) ? int'(rx_q[0]) : 0);
        chk("cpu_tx_ready", cpu_tx_ready, int'(tx_q.size() < DEPTH));
        chk("ext_tx_valid", ext_tx_valid, int'(tx_q.size() > 0));
        chk("ext_tx_data",  ext_tx_data,  (tx_q.size() > 0) ? int'(tx_q[0]) : 0);
`ifdef SERIAL_BRIDGE_STATUS_EN
        chk("rx_count",     rx_count,     rx_q.size());
        chk("tx_count",     tx_count,     tx_q.size());
        chk("tx_drop",      tx_drop,      m_tx_drop);
        chk("rx_underflow", rx_underflow, m_rx_uf);
`endif
        rx_push = ext_rx_valid && (rx_q.size() < DEPTH);
        rx_pop  = cpu_rx_rden  && (rx_q.size() > 0);
        tx_push = cpu_tx_wren  && (tx_q.size() < DEPTH);
        tx_pop  = ext_tx_ready && (tx_q.size() > 0);
        if (cpu_tx_wren && tx_q.size() == DEPTH) m_tx_drop = 1'b1;
        if (cpu_rx_rden && rx_q.size() == 0)     m_rx_uf   = 1'b1;
        if (rx_pop)  void'(rx_q.pop_front());
        if (rx_push) rx_q.push_back(ext_rx_data);
        if (tx_pop)  void'(tx_q.pop_front());
        if (tx_push) tx_q.push_back(cpu_tx_data);
      end
    end
  end

  // Stimulus
  initial begin
    logic [7:0] exp_b;
    reset        = 1'b0;
    ext_rx_data  = 8'h5A;
    ext_rx_valid = 1'b1;
    cpu_rx_rden  = 1'b0;
    cpu_tx_data  = 8'hC3;
    cpu_tx_wren  = 1'b1;
    ext_tx_ready = 1'b0;

    // Reset held two edges with requests active.
    step();
    sb_en = 1'b1;
    step();
    chk("reset_rx_ready", ext_rx_ready, 0);
    chk("reset_tx_valid", ext_tx_valid, 0);
    reset        = 1'b1;
    ext_rx_valid = 1'b0;
    cpu_tx_wren  = 1'b0;
    step();
    chk("post_reset_rx_ready", ext_rx_ready, 1);
    chk("post_reset_tx_ready", cpu_tx_ready, 1);
    chk("post_reset_rx_valid", cpu_rx_valid, 0);

    // RX latency and order.
    ext_rx_valid = 1'b1; ext_rx_data = 8'hA5;
    step();
    chk("rx_lat_valid", cpu_rx_valid, 1);
    chk("rx_lat_data",  cpu_rx_data,  8'hA5);
    ext_rx_data = 8'h3C;
    step();
    ext_rx_valid = 1'b0;
    cpu_rx_rden  = 1'b1;
    step();
    chk("rx_second", cpu_rx_data, 8'h3C);
    step();
    cpu_rx_rden = 1'b0;
    chk("rx_empty_valid", cpu_rx_valid, 0);
    chk("rx_empty_data",  cpu_rx_data,  0);

    // RX full, blocked push, one pop, then wrap-around drain.
    for (int i = 0; i < DEPTH; i++) begin
      ext_rx_valid = 1'b1; ext_rx_data = 8'(i);
      step();
    end
    chk("rx_full_ready", ext_rx_ready, 0);
    ext_rx_data = 8'hFF;
    step();
    chk("rx_full_blocked", ext_rx_ready, 0);
    cpu_rx_rden = 1'b1;
    step();
    cpu_rx_rden = 1'b0;
    chk("rx_ready_after_pop", ext_rx_ready, 1);
    step();
    ext_rx_valid = 1'b0;
    chk("rx_full_again", ext_rx_ready, 0);
    cpu_rx_rden = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      exp_b = (i == DEPTH) ? 8'hFF : 8'(i);
      chk("rx_drain", cpu_rx_data, exp_b);
      step();
    end
    cpu_rx_rden = 1'b0;
    chk("rx_drained", cpu_rx_valid, 0);

    // Simultaneous push and pop at occupancy 3.
    ext_rx_valid = 1'b1;
    ext_rx_data = 8'h10; step();
    ext_rx_data = 8'h20; step();
    ext_rx_data = 8'h30; step();
    ext_rx_data = 8'h40; cpu_rx_rden = 1'b1;
    step();
    ext_rx_valid = 1'b0; cpu_rx_rden = 1'b0;
    chk("rx_simul_head", cpu_rx_data, 8'h20);
`ifdef SERIAL_BRIDGE_STATUS_EN
    chk("rx_simul_count", rx_count, 3);
`endif
    cpu_rx_rden = 1'b1;
    repeat (3) step();
    cpu_rx_rden = 1'b0;

    // TX backpressure.
    ext_tx_ready = 1'b0;
    cpu_tx_wren  = 1'b1;
    cpu_tx_data = 8'h11; step();
    cpu_tx_data = 8'h22; step();
    cpu_tx_data = 8'h33; step();
    cpu_tx_wren = 1'b0;
    step();
    chk("tx_held_valid", ext_tx_valid, 1);
    chk("tx_held_data",  ext_tx_data,  8'h11);
    ext_tx_ready = 1'b1;
    step(); chk("tx_out2", ext_tx_data, 8'h22);
    step(); chk("tx_out3", ext_tx_data, 8'h33);
    step(); chk("tx_done", ext_tx_valid, 0);
    ext_tx_ready = 1'b0;

    // TX fill, dropped write, RX underflow.
    cpu_tx_wren = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      cpu_tx_data = 8'(8'h80 + i);
      step();
    end
    chk("tx_full_ready", cpu_tx_ready, 0);
    cpu_tx_data = 8'h99;
    step();
    cpu_tx_wren = 1'b0;
    cpu_rx_rden = 1'b1;
    step();
    cpu_rx_rden = 1'b0;
    step();
`ifdef SERIAL_BRIDGE_STATUS_EN
    chk("tx_drop_set",      tx_drop,      1);
    chk("rx_underflow_set", rx_underflow, 1);
    chk("tx_count_full",    tx_count,     DEPTH);
`endif
    ext_tx_ready = 1'b1;
    repeat (4) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    ext_tx_ready = 1'b0;
`ifdef SERIAL_BRIDGE_STATUS_EN
    chk("tx_drop_clr",      tx_drop,      0);
    chk("rx_underflow_clr", rx_underflow, 0);
`endif
    chk("reset_discard", ext_tx_valid, 0);

    // Randomized traffic with varying biases and occasional resets.
    for (int blk = 0; blk < 6; blk++) begin
      int push_bias, pop_bias;
      push_bias = $urandom_range(1, 9);
      pop_bias  = $urandom_range(1, 9);
      for (int c = 0; c < 500; c++) begin
        ext_rx_valid = ($urandom_range(0, 9) < push_bias);
        ext_rx_data  = 8'($urandom);
        cpu_rx_rden  = ($urandom_range(0, 9) < pop_bias);
        cpu_tx_wren  = ($urandom_range(0, 9) < pop_bias);
        cpu_tx_data  = 8'($urandom);
        ext_tx_ready = ($urandom_range(0, 9) < push_bias);
        reset        = ($urandom_range(0, 399) != 0);
        step();
      end
    end
    reset        = 1'b1;
    ext_rx_valid = 1'b0;
    cpu_rx_rden  = 1'b0;
    cpu_tx_wren  = 1'b0;
    ext_tx_ready = 1'b0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
